// File: rtl/bitcoin_pkg.sv
// Shared types and helpers for the nonce sweep scheduler.
//   - sched_state_e : scheduler FSM states
//   - hash256_t     : 256-bit hash / target value
//   - blk_header_t  : latched block header fields presented to the hash core
//   - byte_swap     : reverses byte order of a 256-bit word (core output -> numeric hash)
package bitcoin_pkg;

  localparam int unsigned WORD_W               = 32;
  localparam int unsigned HASH_W               = 256;
  localparam int unsigned HASH_BYTES           = HASH_W / 8;
  localparam int unsigned DEFAULT_CORE_TIMEOUT = 4096;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [HASH_W-1:0] hash256_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    FOUND   = 3'd4,
    EXHAUST = 3'd5,
    ABORT   = 3'd6
  } sched_state_e;

  typedef struct packed {
    word_t    version;
    hash256_t prev_hash;
    hash256_t merkle_root;
    word_t    blk_time;
    word_t    nbits;
  } blk_header_t;

  // Core delivers the digest little-endian; the numeric compare needs it big-endian.
  function automatic hash256_t byte_swap(input hash256_t v);
    hash256_t r;
    for (int i = 0; i < int'(HASH_BYTES); i++) begin
      r[8*i +: 8] = v[8*(int'(HASH_BYTES) - 1 - i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_timeout_counter.sv
// Down-counter bounding how long the scheduler waits on the hash core.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : arm the counter for a fresh wait window of LIMIT cycles
//   enable     : one waiting cycle has elapsed
//   expire     : registered; high during the LIMIT-th enabled cycle after load
module nonce_timeout_counter #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  // Remaining enabled cycles before expiry; expire flags the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt_q  <= CW'(LIMIT - 1);
      expire <= (LIMIT <= 1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CW'(1);
      expire <= (cnt_q == CW'(1));
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Sweeps a nonce range through an external double-SHA256 core and reports the
// first nonce whose byte-swapped digest is <= target.
// Ports:
//   clk, reset            : clock, async active-low reset
//   start, stop           : launch a sweep (ignored while busy) / abort it
//   blk_*, prev/merkle    : header fields latched at start
//   nonce_first/last      : inclusive sweep range (wraps through 0 if first > last)
//   target                : 256-bit threshold
//   core_*  (out)         : header + nonce to the core, one-cycle core_start
//   core_blk, core_done   : digest and completion strobe from the core
//   busy/found/exhausted/timeout_err/attempts/found_nonce/found_hash : status
module nonce_scheduler
  import bitcoin_pkg::*;
#(
  parameter int unsigned CORE_TIMEOUT = DEFAULT_CORE_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WORD_W-1:0] blk_version,
  input  logic [WORD_W-1:0] blk_time,
  input  logic [WORD_W-1:0] blk_nbits,
  input  logic [HASH_W-1:0] prev_blk_header_hash,
  input  logic [HASH_W-1:0] merkle_root_hash,
  input  logic [WORD_W-1:0] nonce_first,
  input  logic [WORD_W-1:0] nonce_last,
  input  logic [HASH_W-1:0] target,
  output logic              core_start,
  output logic [WORD_W-1:0] core_blk_version,
  output logic [WORD_W-1:0] core_blk_time,
  output logic [WORD_W-1:0] core_blk_nbits,
  output logic [WORD_W-1:0] core_blk_nonce,
  output logic [HASH_W-1:0] core_prev_hash,
  output logic [HASH_W-1:0] core_merkle,
  input  logic [HASH_W-1:0] core_blk,
  input  logic              core_done,
  output logic              busy,
  output logic              found,
  output logic [WORD_W-1:0] found_nonce,
  output logic [HASH_W-1:0] found_hash,
  output logic              exhausted,
  output logic              timeout_err,
  output logic [WORD_W-1:0] attempts
);

  sched_state_e state_q;
  sched_state_e state_nxt;

  blk_header_t  hdr_q;
  word_t        nonce_q;
  word_t        nonce_last_q;
  hash256_t     target_q;
  hash256_t     blk_q;

  logic         tmo_load;
  logic         tmo_en;
  logic         tmo_expire;
  logic         hit_c;
  logic         last_c;

  // Header and nonce registers drive the core directly, so they stay steady per sweep.
  assign core_blk_version = hdr_q.version;
  assign core_blk_time    = hdr_q.blk_time;
  assign core_blk_nbits   = hdr_q.nbits;
  assign core_prev_hash   = hdr_q.prev_hash;
  assign core_merkle      = hdr_q.merkle_root;
  assign core_blk_nonce   = nonce_q;

  // Target compare on the captured digest, evaluated while in CHECK.
  assign hit_c  = (byte_swap(blk_q) <= target_q);
  assign last_c = (nonce_q == nonce_last_q);

  // Timeout window is armed in LAUNCH and counts WAIT cycles.
  assign tmo_load = (state_q == LAUNCH);
  assign tmo_en   = (state_q == WAIT);

  nonce_timeout_counter #(
    .LIMIT (CORE_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (reset),
    .load   (tmo_load),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  // Next-state decode; stop overrides everything outside IDLE.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (start) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (core_done)       state_nxt = CHECK;
        else if (tmo_expire) state_nxt = ABORT;
      end
      CHECK: begin
        if (hit_c)       state_nxt = FOUND;
        else if (last_c) state_nxt = EXHAUST;
        else             state_nxt = LAUNCH;
      end
      FOUND:   state_nxt = IDLE;
      EXHAUST: state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop && (state_q != IDLE) && (state_q != ABORT)) begin
      state_nxt = ABORT;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hdr_q        <= '0;
      nonce_q      <= '0;
      nonce_last_q <= '0;
      target_q     <= '0;
      blk_q        <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      found_nonce  <= '0;
      found_hash   <= '0;
      exhausted    <= 1'b0;
      timeout_err  <= 1'b0;
      attempts     <= '0;
    end else begin
      state_q    <= state_nxt;
      busy       <= (state_nxt != IDLE);
      core_start <= (state_nxt == LAUNCH);

      unique case (state_q)
        IDLE: begin
          if (start) begin
            hdr_q.version     <= blk_version;
            hdr_q.prev_hash   <= prev_blk_header_hash;
            hdr_q.merkle_root <= merkle_root_hash;
            hdr_q.blk_time    <= blk_time;
            hdr_q.nbits       <= blk_nbits;
            nonce_q           <= nonce_first;
            nonce_last_q      <= nonce_last;
            target_q          <= target;
            found             <= 1'b0;
            found_nonce       <= '0;
            found_hash        <= '0;
            exhausted         <= 1'b0;
            timeout_err       <= 1'b0;
            attempts          <= '0;
          end
        end
        WAIT: begin
          if (state_nxt == CHECK) blk_q <= core_blk;
          // Only the expiry path reaches ABORT without stop.
          if ((state_nxt == ABORT) && !stop) timeout_err <= 1'b1;
        end
        CHECK: begin
          if (attempts != '1) attempts <= attempts + WORD_W'(1);
          // 32-bit add wraps FFFFFFFF -> 0, giving wrap-around ranges for free.
          if (state_nxt == LAUNCH) nonce_q <= nonce_q + WORD_W'(1);
        end
        FOUND: begin
          if (state_nxt == IDLE) begin
            found       <= 1'b1;
            found_nonce <= nonce_q;
            found_hash  <= blk_q;
          end
        end
        EXHAUST: begin
          if (state_nxt == IDLE) exhausted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency behavioural hash core.
module tb_nonce_scheduler;

  localparam int unsigned CORE_LAT = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic [31:0]  blk_version, blk_time, blk_nbits;
  logic [255:0] prev_blk_header_hash, merkle_root_hash;
  logic [31:0]  nonce_first, nonce_last;
  logic [255:0] target;
  logic         core_start;
  logic [31:0]  core_blk_version, core_blk_time, core_blk_nbits, core_blk_nonce;
  logic [255:0] core_prev_hash, core_merkle;
  logic [255:0] core_blk;
  logic         core_done;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  found_nonce, attempts;
  logic [255:0] found_hash;

  // Block 125552 header fields.
  localparam logic [31:0]  HV_VERSION = 32'h0000_0001;
  localparam logic [31:0]  HV_TIME    = 32'h4dd7_f5c7;
  localparam logic [31:0]  HV_NBITS   = 32'h1a44_b9f2;
  localparam logic [255:0] HV_PREV    = 256'h00000000000008a3a41b85b8b29ad444def299fee21793cd8b9e567eab02cd81;
  localparam logic [255:0] HV_MERKLE  = 256'h2b12fcf1b09288fcaff797d71e950e71ae42b91e8bdb2304758dfcffc2b620e3;
  localparam logic [255:0] TGT_TOP0   = {32'h0, {224{1'b1}}};

  int n_vec;
  int n_err;
  int n_starts;
  logic [31:0] order[$];

  logic [31:0] hit_nonce;
  logic        mute;
  int unsigned mdl_cnt;
  logic [31:0] mdl_nonce;

  nonce_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .stop                 (stop),
    .blk_version          (blk_version),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .nonce_first          (nonce_first),
    .nonce_last           (nonce_last),
    .target               (target),
    .core_start           (core_start),
    .core_blk_version     (core_blk_version),
    .core_blk_time        (core_blk_time),
    .core_blk_nbits       (core_blk_nbits),
    .core_blk_nonce       (core_blk_nonce),
    .core_prev_hash       (core_prev_hash),
    .core_merkle          (core_merkle),
    .core_blk             (core_blk),
    .core_done            (core_done),
    .busy                 (busy),
    .found                (found),
    .found_nonce          (found_nonce),
    .found_hash           (found_hash),
    .exhausted            (exhausted),
    .timeout_err          (timeout_err),
    .attempts             (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] swap256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  // Numeric hash: top word zero only at hit_nonce.
  function automatic logic [255:0] model_hash(input logic [31:0] n);
    logic [31:0] top;
    top = (n == hit_nonce) ? 32'h0 : 32'hFFFF_FFFF;
    return {top, n, 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978};
  endfunction

  // Behavioural core: digest (little-endian) appears CORE_LAT cycles after core_start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_cnt   <= 0;
      mdl_nonce <= '0;
      core_done <= 1'b0;
      core_blk  <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        mdl_cnt   <= CORE_LAT;
        mdl_nonce <= core_blk_nonce;
      end else if (mdl_cnt == 1) begin
        mdl_cnt <= 0;
        if (!mute) begin
          core_done <= 1'b1;
          core_blk  <= swap256(model_hash(mdl_nonce));
        end
      end else if (mdl_cnt > 1) begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && core_start) begin
      n_starts++;
      order.push_back(core_blk_nonce);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] first, input logic [31:0] last, input logic [255:0] tgt);
    @(negedge clk);
    nonce_first = first;
    nonce_last  = last;
    target      = tgt;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("idle_in_budget", 256'(busy), 256'(0));
  endtask

  initial begin
    int cyc;
    int last_done;
    int s0;

    n_vec = 0; n_err = 0; n_starts = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; mute = 1'b0;
    hit_nonce = 32'hDEAD_0000;
    blk_version = HV_VERSION; blk_time = HV_TIME; blk_nbits = HV_NBITS;
    prev_blk_header_hash = HV_PREV; merkle_root_hash = HV_MERKLE;
    nonce_first = '0; nonce_last = '0; target = '0;

    // Reset state
    #1;
    check("rst_busy",       256'(busy),           256'(0));
    check("rst_core_start", 256'(core_start),     256'(0));
    check("rst_found",      256'(found),          256'(0));
    check("rst_attempts",   256'(attempts),       256'(0));
    check("rst_core_prev",  core_prev_hash,       256'(0));
    check("rst_found_hash", found_hash,           256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single nonce, target all ones
    s0 = n_starts;
    launch(32'h43F7_40C0, 32'h43F7_40C0, {256{1'b1}});
    check("s1_core_start", 256'(core_start), 256'(1));
    blk_version = 32'h0;
    repeat (5) @(negedge clk);
    check("s1_hdr_version", 256'(core_blk_version), 256'(HV_VERSION));
    check("s1_hdr_time",    256'(core_blk_time),    256'(HV_TIME));
    check("s1_hdr_nbits",   256'(core_blk_nbits),   256'(HV_NBITS));
    check("s1_hdr_prev",    core_prev_hash,         HV_PREV);
    check("s1_hdr_merkle",  core_merkle,            HV_MERKLE);
    check("s1_core_nonce",  256'(core_blk_nonce),   256'(32'h43F7_40C0));
    check("s1_busy",        256'(busy),             256'(1));
    wait_idle(500);
    blk_version = HV_VERSION;
    check("s1_found",       256'(found),       256'(1));
    check("s1_found_nonce", 256'(found_nonce), 256'(32'h43F7_40C0));
    check("s1_attempts",    256'(attempts),    256'(1));
    check("s1_exhausted",   256'(exhausted),   256'(0));
    check("s1_starts",      256'(n_starts - s0), 256'(1));
    check("s1_found_hash",  found_hash, swap256(model_hash(32'h43F7_40C0)));

    // Hit mid-range at nonce 5; a second start while busy must be ignored
    hit_nonce = 32'd5;
    s0 = n_starts;
    launch(32'd0, 32'd9, TGT_TOP0);
    repeat (20) @(negedge clk);
    nonce_first = 32'd100; nonce_last = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);
    check("s2_found",       256'(found),          256'(1));
    check("s2_found_nonce", 256'(found_nonce),    256'(5));
    check("s2_attempts",    256'(attempts),       256'(6));
    check("s2_starts",      256'(n_starts - s0),  256'(6));
    check("s2_found_hash",  found_hash, swap256(model_hash(32'd5)));

    // Miss: target 0, range 0..3; busy falls 3 cycles after the last core_done
    hit_nonce = 32'hDEAD_0000;
    launch(32'd0, 32'd3, 256'(0));
    cyc = 0; last_done = -100;
    while (busy && cyc < 2000) begin
      if (core_done) last_done = cyc;
      @(negedge clk);
      cyc++;
    end
    check("s3_busy_fall",  256'(cyc - last_done), 256'(3));
    check("s3_exhausted",  256'(exhausted),       256'(1));
    check("s3_found",      256'(found),           256'(0));
    check("s3_attempts",   256'(attempts),        256'(4));

    // Wrap-around range
    order.delete();
    launch(32'hFFFF_FFFE, 32'h0000_0001, 256'(0));
    wait_idle(2000);
    check("s4_count",     256'(order.size()), 256'(4));
    if (order.size() == 4) begin
      check("s4_n0", 256'(order[0]), 256'(32'hFFFF_FFFE));
      check("s4_n1", 256'(order[1]), 256'(32'hFFFF_FFFF));
      check("s4_n2", 256'(order[2]), 256'(32'h0000_0000));
      check("s4_n3", 256'(order[3]), 256'(32'h0000_0001));
    end
    check("s4_exhausted", 256'(exhausted), 256'(1));

    // Stop in the same cycle as core_done: stop wins
    launch(32'd10, 32'd10, {256{1'b1}});
    cyc = 0;
    while (!core_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("s5_done_seen", 256'(core_done), 256'(1));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(20);
    check("s5_found",     256'(found),       256'(0));
    check("s5_exhausted", 256'(exhausted),   256'(0));
    check("s5_timeout",   256'(timeout_err), 256'(0));
    check("s5_attempts",  256'(attempts),    256'(0));

    // Core never answers: timeout after 4096 WAIT cycles
    mute = 1'b1;
    launch(32'd0, 32'd0, {256{1'b1}});
    check("s6_core_start", 256'(core_start), 256'(1));
    repeat (4096) @(negedge clk);
    check("s6_tmo_early",  256'(timeout_err), 256'(0));
    check("s6_busy_wait",  256'(busy),        256'(1));
    @(negedge clk);
    check("s6_tmo_set",    256'(timeout_err), 256'(1));
    @(negedge clk);
    check("s6_idle",       256'(busy),        256'(0));
    check("s6_found",      256'(found),       256'(0));
    mute = 1'b0;

    // Reset mid-WAIT, then a clean sweep
    launch(32'h43F7_40C0, 32'h43F7_40C0, {256{1'b1}});
    repeat (10) @(negedge clk);
    check("s7_pre_nonce", 256'(core_blk_nonce), 256'(32'h43F7_40C0));
    reset = 1'b0;
    #1;
    check("s7_rst_busy",   256'(busy),           256'(0));
    check("s7_rst_nonce",  256'(core_blk_nonce), 256'(0));
    check("s7_rst_merkle", core_merkle,          256'(0));
    check("s7_rst_tmo",    256'(timeout_err),    256'(0));
    @(negedge clk);
    reset = 1'b1;
    s0 = n_starts;
    repeat (100) @(negedge clk);
    check("s7_quiet_busy",   256'(busy),           256'(0));
    check("s7_quiet_starts", 256'(n_starts - s0),  256'(0));
    check("s7_quiet_done",   256'(found),          256'(0));
    launch(32'h43F7_40C0, 32'h43F7_40C0, {256{1'b1}});
    wait_idle(500);
    check("s7_found",       256'(found),       256'(1));
    check("s7_found_nonce", 256'(found_nonce), 256'(32'h43F7_40C0));
    check("s7_attempts",    256'(attempts),    256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter CORE_TIMEOUT, default 4096: max cycles from core_start to core_done before abort.
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have start (in, 1): one-cycle pulse that launches a sweep; stop (in, 1): abort the sweep.
REQ-004 SHALL have header inputs blk_version, blk_time and blk_nbits (in, 32 each), and prev_blk_header_hash and merkle_root_hash (in, 256 each).
REQ-005 SHALL have nonce_first, nonce_last (in, 32): inclusive sweep range, and target (in, 256): threshold.
REQ-006 SHALL have core-side outputs core_start (1), core_blk_version, core_blk_time, core_blk_nbits, core_blk_nonce (32 each), core_prev_hash and core_merkle (256 each), and core-side inputs core_blk (256) and core_done (1).
REQ-007 SHALL have outputs busy (1), found (1), found_nonce (32), found_hash (256), exhausted (1), timeout_err (1) and attempts (32).

Function
REQ-008 SHALL use states IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUST and ABORT.
REQ-009 In IDLE, start=1 SHALL latch all header fields, nonce_first, nonce_last and target; the block SHALL clear found, exhausted, timeout_err and attempts, and go to LAUNCH.
REQ-010 start SHALL be ignored while busy=1.
REQ-011 LAUNCH SHALL assert core_start for exactly one cycle with core_blk_nonce equal to the current nonce, then go to WAIT.
REQ-012 Core-side header outputs SHALL hold the latched values steady for the whole sweep.
REQ-013 WAIT SHALL count cycles and go to CHECK on core_done=1.
REQ-014 If the WAIT count reaches CORE_TIMEOUT, the block SHALL set timeout_err and go to ABORT.
REQ-015 CHECK SHALL register core_blk and increment attempts (saturating at 32'hFFFFFFFF).
REQ-016 CHECK SHALL compute the hash value as byte_swap(core_blk); if hash value <= target (unsigned 256-bit), it SHALL go to FOUND.
REQ-017 Otherwise, if nonce == nonce_last, CHECK SHALL go to EXHAUST.
REQ-018 Otherwise, CHECK SHALL increment the nonce (32-bit) and go to LAUNCH.
REQ-019 The nonce increment SHALL wrap 32'hFFFFFFFF to 0; a range with nonce_first > nonce_last SHALL therefore sweep through the wrap-around.
REQ-020 FOUND SHALL set found=1, found_nonce = current nonce and found_hash = core_blk, then go to IDLE; these outputs SHALL hold until the next accepted start.
REQ-021 EXHAUST SHALL set exhausted=1 and go to IDLE.
REQ-022 ABORT SHALL go to IDLE; it SHALL not launch the core again and SHALL not wait for an outstanding core_done.
REQ-023 stop=1 in any non-IDLE state SHALL go to ABORT next cycle without asserting found or exhausted; stop SHALL take priority over a simultaneous core_done.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 If nonce_first == nonce_last, the sweep SHALL make exactly one attempt.
REQ-026 core_done received outside WAIT SHALL be ignored.
REQ-027 Per-nonce latency SHALL be core latency + 3 cycles (LAUNCH, the WAIT exit, CHECK).

Reset
REQ-028 While reset=0, the block SHALL asynchronously go to IDLE and drive core_start=0, busy=0, found=0, exhausted=0, timeout_err=0, attempts=0, found_nonce=0 and found_hash=0.
REQ-029 While reset=0, all latched fields and core-side data outputs SHALL be 0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep; the block SHALL start nothing until a new start after reset is released.

Structure
REQ-031 Package bitcoin_pkg SHALL hold the state enum, the 256-bit hash typedef, the byte_swap function and the default CORE_TIMEOUT constant.
REQ-032 A sub-module nonce_timeout_counter (load/enable/expire) is natural and SHALL be used for the WAIT timeout.
REQ-033 The hash compare SHALL be combinational within CHECK.

Verification
REQ-034 Bench SHALL use a behavioural core model with fixed latency 64 that returns a hash as a function of nonce.
REQ-035 Scenario SHALL be single nonce: header from the standard block vector, nonce_first = nonce_last = 32'h43F740C0, target = all ones -> found=1, found_nonce=32'h43F740C0, attempts=1.
REQ-036 Scenario SHALL be a hit mid-range: range 0..9 with the model hit at nonce 5 -> found_nonce=5, attempts=6, exactly 6 core_start pulses.
REQ-037 Scenario SHALL be miss: range 0..3, target = 0 -> exhausted=1, found=0, attempts=4, busy falls 3 cycles after the last core_done.
REQ-038 Scenario SHALL be wrap: range 32'hFFFFFFFE..32'h00000001, no hit -> nonce order FFFFFFFE, FFFFFFFF, 0, 1, then exhausted=1.
REQ-039 Scenario SHALL be stop/timeout: stop in the cycle core_done arrives -> found=0 and IDLE.
REQ-040 Scenario SHALL be core that never returns core_done -> timeout_err=1 after 4096 WAIT cycles.
REQ-041 Scenario SHALL be reset mid-WAIT -> all outputs 0 immediately, and the next start runs normally.
